// File: rtl/sonic_rx_ctl_if.sv
// Bundle of the PHY receive stream, DMA pop port and rx_prg register port of sonic_rx_ctl.
// The block under control uses the slave view; whoever drives it uses the master view.
interface sonic_rx_ctl_if;
  logic         rx_valid;
  logic [39:0]  rx_data;
  logic         rd_req;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         empty;
  logic         full;
  logic         almost_full;
  logic         almost_empty;
  logic         rx_prg_wrena;
  logic [31:0]  rx_prg_wrdata;
  logic [7:0]   rx_prg_addr;
  logic [31:0]  rx_prg_rddata;

  modport master (
    output rx_valid, rx_data, rd_req, rx_prg_wrena, rx_prg_wrdata, rx_prg_addr,
    input  rd_data, rd_valid, empty, full, almost_full, almost_empty, rx_prg_rddata
  );

  modport slave (
    input  rx_valid, rx_data, rd_req, rx_prg_wrena, rx_prg_wrdata, rx_prg_addr,
    output rd_data, rd_valid, empty, full, almost_full, almost_empty, rx_prg_rddata
  );
endinterface

// File: rtl/sonic_rx_ctl.sv
// Receive control path: packs 40-bit PHY words into 128-bit owords, queues them in a
// circular buffer drained by DMA pops, and exposes control/status on the rx_prg port.
module sonic_rx_ctl #(
  parameter int ADDR_WIDTH          = 8,
  parameter int ALMOST_FULL_THRESH  = 240,
  parameter int ALMOST_EMPTY_THRESH = 4
) (
  input  logic           clock,
  input  logic           reset,
  sonic_rx_ctl_if.slave  bus
);
  localparam int LW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(ALMOST_FULL_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(ALMOST_EMPTY_THRESH);

  logic [167:0]  acc_r;
  logic [6:0]    fill_r;
  logic [LW-1:0] wr_ptr_r;
  logic [LW-1:0] rd_ptr_r;
  logic [127:0]  mem_r [0:DEPTH-1];
  logic          en_r;
  logic [31:0]   ovf_r;
  logic [31:0]   owords_r;
  logic [127:0]  rd_data_r;
  logic          rd_valid_r;
  logic          empty_r;
  logic          full_r;
  logic          almost_full_r;
  logic          almost_empty_r;
  logic [31:0]   prg_rddata_r;

  logic [167:0]  acc_ins_s;
  logic [167:0]  acc_nxt_s;
  logic [7:0]    n_s;
  logic [6:0]    fill_nxt_s;
  logic          emit_s;
  logic [127:0]  emit_word_s;
  logic          ctrl_wr_s;
  logic          flush_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [LW-1:0] wr_nxt_s;
  logic [LW-1:0] rd_nxt_s;
  logic [LW-1:0] level_s;
  logic [LW-1:0] level_nxt_s;
  logic [31:0]   status_s;
  logic [31:0]   rd_mux_s;
  logic          unused_s;

  assign ctrl_wr_s = bus.rx_prg_wrena && (bus.rx_prg_addr == 8'h00);
  assign flush_s   = ctrl_wr_s && bus.rx_prg_wrdata[1];
  assign unused_s  = ^bus.rx_prg_wrdata[31:2];

  // Gearbox: place the new word at the fill point, emit 128 bits once enough are held.
  always_comb begin
    acc_ins_s                 = acc_r;
    acc_ins_s[fill_r +: 40]   = bus.rx_data;
    n_s                       = {1'b0, fill_r} + 8'd40;
    acc_nxt_s                 = acc_r;
    fill_nxt_s                = fill_r;
    emit_s                    = 1'b0;
    emit_word_s               = 128'd0;
    if (flush_s) begin
      if (fill_r != 7'd0) begin
        emit_s      = 1'b1;
        emit_word_s = acc_r[127:0] & ~({128{1'b1}} << fill_r);
      end else begin
        emit_s      = 1'b0;
      end
      acc_nxt_s  = 168'd0;
      fill_nxt_s = 7'd0;
    end else if (bus.rx_valid && en_r) begin
      if (n_s >= 8'd128) begin
        emit_s      = 1'b1;
        emit_word_s = acc_ins_s[127:0];
        acc_nxt_s   = {128'd0, acc_ins_s[167:128]};
        fill_nxt_s  = 7'(n_s - 8'd128);
      end else begin
        acc_nxt_s   = acc_ins_s;
        fill_nxt_s  = n_s[6:0];
      end
    end else begin
      acc_nxt_s  = acc_r;
      fill_nxt_s = fill_r;
    end
  end

  // Buffer bookkeeping: a full buffer still accepts a push when a pop frees the slot.
  always_comb begin
    pop_s       = bus.rd_req && !empty_r;
    push_s      = emit_s && (!full_r || pop_s);
    drop_s      = emit_s && full_r && !pop_s;
    wr_nxt_s    = push_s ? (wr_ptr_r + LW'(1)) : wr_ptr_r;
    rd_nxt_s    = pop_s  ? (rd_ptr_r + LW'(1)) : rd_ptr_r;
    level_s     = wr_ptr_r - rd_ptr_r;
    level_nxt_s = wr_nxt_s - rd_nxt_s;
  end

  // Register read mux; unmapped addresses read as zero.
  always_comb begin
    status_s              = 32'd0;
    status_s[ADDR_WIDTH:0] = level_s;
    status_s[16]          = empty_r;
    status_s[17]          = full_r;
    status_s[18]          = almost_full_r;
    status_s[19]          = almost_empty_r;
    status_s[26:20]       = fill_r;
    case (bus.rx_prg_addr)
      8'h00:   rd_mux_s = {31'd0, en_r};
      8'h01:   rd_mux_s = status_s;
      8'h02:   rd_mux_s = ovf_r;
      8'h03:   rd_mux_s = owords_r;
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Buffer storage; a same-cycle pop at the same slot reads the old entry.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= emit_word_s;
    end
  end

  // Control state, counters, registered flags and outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r          <= 168'd0;
      fill_r         <= 7'd0;
      wr_ptr_r       <= {LW{1'b0}};
      rd_ptr_r       <= {LW{1'b0}};
      en_r           <= 1'b0;
      ovf_r          <= 32'd0;
      owords_r       <= 32'd0;
      rd_data_r      <= 128'd0;
      rd_valid_r     <= 1'b0;
      empty_r        <= 1'b1;
      full_r         <= 1'b0;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      prg_rddata_r   <= 32'd0;
    end else begin
      acc_r      <= acc_nxt_s;
      fill_r     <= fill_nxt_s;
      wr_ptr_r   <= wr_nxt_s;
      rd_ptr_r   <= rd_nxt_s;
      rd_valid_r <= pop_s;
      if (pop_s) begin
        rd_data_r <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
      end
      if (drop_s && (ovf_r != 32'hFFFF_FFFF)) begin
        ovf_r <= ovf_r + 32'd1;
      end
      if (push_s) begin
        owords_r <= owords_r + 32'd1;
      end
      if (ctrl_wr_s) begin
        en_r <= bus.rx_prg_wrdata[0];
      end
      empty_r        <= (level_nxt_s == {LW{1'b0}});
      full_r         <= (level_nxt_s == DEPTH_L);
      almost_full_r  <= (level_nxt_s >= AF_L);
      almost_empty_r <= (level_nxt_s <= AE_L);
      prg_rddata_r   <= rd_mux_s;
    end
  end

  assign bus.rd_data       = rd_data_r;
  assign bus.rd_valid      = rd_valid_r;
  assign bus.empty         = empty_r;
  assign bus.full          = full_r;
  assign bus.almost_full   = almost_full_r;
  assign bus.almost_empty  = almost_empty_r;
  assign bus.rx_prg_rddata = prg_rddata_r;
endmodule
